systolic_run_seq: RTL and testbench

SYSTOLIC_RUN_SEQ -- requirements
Module: systolic_run_seq

---
 rtl/systolic_pkg.sv | 11 +
 rtl/systolic_run_seq.sv | 147 ++++++++++++++
 tb/tb_systolic_run_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and control-register map for the systolic run sequencer
package systolic_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_WR_MAX, S_WR_RUN, S_WR_START, S_POLL_REQ,
      S_POLL_WAIT, S_RD_REQ, S_RD_WAIT, S_RD_OUT, S_FIN
   } state_t;
   localparam logic [15:0] ADR_START = 16'hFFF0;
   localparam logic [15:0] ADR_MAX   = 16'hFFF1;
   localparam logic [15:0] ADR_RUN   = 16'hFFF2;
   localparam logic [8:0]  STAT_OFS  = 9'h100;
endpackage

// File: rtl/systolic_run_seq.sv
// systolic_run_seq: programs a systolic run, polls for completion, then drains all output buffers
module systolic_run_seq import systolic_pkg::*; #(
   parameter int          NUM_OBUF       = 4,
   parameter int          OBUF_DEPTH     = 8,
   parameter logic [6:0]  OBUF_HEAD_BASE = 7'h40,
   parameter int          STAT_EN        = 1,
   parameter int          POLL_MAX       = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] max_cntr,
   input  logic [15:0] run_cntr,
   output logic        wen,
   output logic [15:0] ibus_wadr,
   output logic [15:0] ibus_wdata,
   output logic        ren,
   output logic [15:0] ibus_radr,
   input  logic [15:0] ibus_rdata,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic [3:0]  res_buf,
   output logic [8:0]  res_idx,
   output logic        res_stat,
   output logic        done,
   output logic        err
);
   state_t state, state_n;
   logic [15:0] max_q, run_q, data_q, poll_cnt;
   logic [3:0]  buf_q;
   logic [8:0]  idx_q;
   logic        stat_q;
   logic [6:0]  head;
   logic        poll_last, idx_last, buf_last, last_word;
   assign head      = OBUF_HEAD_BASE + {3'b000, buf_q};
   assign poll_last = poll_cnt == 16'(POLL_MAX - 1);
   assign idx_last  = idx_q == 9'(OBUF_DEPTH - 1);
   assign buf_last  = buf_q == 4'(NUM_OBUF - 1);
   assign last_word = buf_last && ((STAT_EN != 0) ? stat_q : idx_last);
   always_ff @(posedge clk)
      state <= rst ? S_IDLE : state_n;
   always_comb begin
      state_n    = state;
      cmd_ready  = 1'b0;
      wen        = 1'b0;
      ibus_wadr  = '0;
      ibus_wdata = '0;
      ren        = 1'b0;
      ibus_radr  = '0;
      res_valid  = 1'b0;
      res_data   = '0;
      res_buf    = '0;
      res_idx    = '0;
      res_stat   = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            state_n   = cmd_valid ? S_WR_MAX : S_IDLE;
         end
         S_WR_MAX: begin
            wen        = 1'b1;
            ibus_wadr  = ADR_MAX;
            ibus_wdata = max_q;
            state_n    = S_WR_RUN;
         end
         S_WR_RUN: begin
            wen        = 1'b1;
            ibus_wadr  = ADR_RUN;
            ibus_wdata = run_q;
            state_n    = S_WR_START;
         end
         S_WR_START: begin
            wen        = 1'b1;
            ibus_wadr  = ADR_START;
            ibus_wdata = 16'hFFFF;
            state_n    = S_POLL_REQ;
         end
         S_POLL_REQ: begin
            ren       = 1'b1;
            ibus_radr = ADR_START;
            state_n   = S_POLL_WAIT;
         end
         S_POLL_WAIT: state_n = (ibus_rdata == '0) ? S_RD_REQ : poll_last ? S_FIN : S_POLL_REQ;
         S_RD_REQ: begin
            ren       = 1'b1;
            ibus_radr = {head, idx_q};
            state_n   = S_RD_WAIT;
         end
         S_RD_WAIT: state_n = S_RD_OUT;
         S_RD_OUT: begin
            res_valid = 1'b1;
            res_data  = data_q;
            res_buf   = buf_q;
            res_idx   = idx_q;
            res_stat  = stat_q;
            state_n   = !res_ready ? S_RD_OUT : last_word ? S_FIN : S_RD_REQ;
         end
         S_FIN: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         max_q    <= '0;
         run_q    <= '0;
         data_q   <= '0;
         poll_cnt <= '0;
         buf_q    <= '0;
         idx_q    <= '0;
         stat_q   <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (state == S_IDLE && cmd_valid) begin
            max_q    <= max_cntr;
            run_q    <= run_cntr;
            poll_cnt <= '0;
            buf_q    <= '0;
            idx_q    <= '0;
            stat_q   <= 1'b0;
            err      <= 1'b0;
         end
         if (state == S_POLL_WAIT && ibus_rdata != '0) begin
            poll_cnt <= poll_cnt + 16'd1;
            if (poll_last) err <= 1'b1;
         end
         if (state == S_RD_WAIT) data_q <= ibus_rdata;
         // walk idx within a buffer, then the status word, then move to the next buffer
         if (state == S_RD_OUT && res_ready) begin
            if (!stat_q && !idx_last) idx_q <= idx_q + 9'd1;
            else if (!stat_q && STAT_EN != 0) begin
               stat_q <= 1'b1;
               idx_q  <= STAT_OFS;
            end else begin
               buf_q  <= buf_q + 4'd1;
               idx_q  <= '0;
               stat_q <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_systolic_run_seq.sv
// tb_systolic_run_seq: table-driven and randomized checks of the run sequencer against a bus model
module tb_systolic_run_seq;
   localparam int L = 1024;
   typedef struct {
      logic [15:0] max;
      logic [15:0] run;
      int          busy;
      int          stall;
      bit          bp;
      logic        exp_err;
      int          exp_nres;
   } scn_t;
   logic clk = 1'b0, rst;
   always #5 clk = ~clk;
   logic        cmd_valid0, cmd_ready0, wen0, ren0, res_valid0, res_ready0, res_stat0, done0, err0;
   logic [15:0] max0, run0, wadr0, wdata0, radr0, rdata0, res_data0;
   logic [3:0]  res_buf0;
   logic [8:0]  res_idx0;
   logic        cmd_valid1, cmd_ready1, wen1, ren1, res_valid1, res_stat1, done1, err1;
   logic [15:0] wadr1, wdata1, radr1, rdata1, res_data1;
   logic [3:0]  res_buf1;
   logic [8:0]  res_idx1;
   systolic_run_seq #(.NUM_OBUF(4), .OBUF_DEPTH(8), .OBUF_HEAD_BASE(7'h40), .STAT_EN(1), .POLL_MAX(4)) d0 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .max_cntr(max0), .run_cntr(run0),
      .wen(wen0), .ibus_wadr(wadr0), .ibus_wdata(wdata0), .ren(ren0), .ibus_radr(radr0), .ibus_rdata(rdata0),
      .res_valid(res_valid0), .res_ready(res_ready0), .res_data(res_data0), .res_buf(res_buf0),
      .res_idx(res_idx0), .res_stat(res_stat0), .done(done0), .err(err0));
   systolic_run_seq #(.NUM_OBUF(1), .OBUF_DEPTH(1), .OBUF_HEAD_BASE(7'h40), .STAT_EN(0)) d1 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .max_cntr(16'h0007), .run_cntr(16'h0009),
      .wen(wen1), .ibus_wadr(wadr1), .ibus_wdata(wdata1), .ren(ren1), .ibus_radr(radr1), .ibus_rdata(rdata1),
      .res_valid(res_valid1), .res_ready(1'b1), .res_data(res_data1), .res_buf(res_buf1),
      .res_idx(res_idx1), .res_stat(res_stat1), .done(done1), .err(err1));
   int busy_polls = 0, stall_at = -1, res_base = 0;
   bit rand_bp = 0;
   int poll_seen;
   // array model: start register stays busy for busy_polls reads after each start write
   always @(posedge clk) begin
      if (rst) begin
         rdata0    <= '0;
         poll_seen <= 0;
      end else begin
         if (wen0 && wadr0 == 16'hFFF0) poll_seen <= 0;
         if (ren0 && radr0 == 16'hFFF0) begin
            rdata0    <= (poll_seen < busy_polls) ? 16'h8001 : 16'h0000;
            poll_seen <= poll_seen + 1;
         end else rdata0 <= ren0 ? (radr0 ^ 16'hA5C3) : 16'hDEAD;
      end
   end
   always @(posedge clk)
      rdata1 <= rst ? 16'h0 : !ren1 ? 16'hDEAD : (radr1 == 16'hFFF0) ? 16'h0 : (radr1 ^ 16'hA5C3);
   logic [31:0] wlog [L];
   logic [15:0] rlog [L];
   logic [29:0] reslog [L];
   int nw = 0, nr = 0, nres = 0, ndone = 0, overlap = 0, unstable = 0;
   logic        pstall = 0;
   logic [29:0] pres;
   always @(negedge clk) begin
      if (wen0) begin wlog[nw % L] = {wadr0, wdata0}; nw++; end
      if (ren0) begin rlog[nr % L] = radr0; nr++; end
      if (wen0 && ren0) overlap++;
      if (done0) ndone++;
      if (!rst && pstall && (!res_valid0 || pres != {res_buf0, res_idx0, res_stat0, res_data0})) unstable++;
      pstall = !rst && res_valid0 && !res_ready0;
      pres   = {res_buf0, res_idx0, res_stat0, res_data0};
      if (res_valid0 && res_ready0) begin reslog[nres % L] = pres; nres++; end
   end
   int nw1 = 0, nres1 = 0, ndone1 = 0;
   logic [15:0] last_rd1 = '0;
   logic [29:0] last_res1 = '0;
   always @(negedge clk) begin
      if (wen1) nw1++;
      if (done1) ndone1++;
      if (ren1 && radr1 != 16'hFFF0) last_rd1 = radr1;
      if (res_valid1) begin last_res1 = {res_buf1, res_idx1, res_stat1, res_data1}; nres1++; end
   end
   initial begin
      int k, sc;
      res_ready0 = 1'b1;
      sc = 0;
      forever begin
         @(posedge clk); #1;
         k = nres - res_base;
         if (stall_at == k && res_valid0 && sc < 5) begin
            res_ready0 = 1'b0;
            sc++;
         end else begin
            res_ready0 = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k != stall_at) sc = 0;
         end
      end
   end
   int total = 0, bad = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   task automatic run_scn(input scn_t s);
      int wb, rb, qb, db, ob, ub, polls, n;
      logic [15:0] er[$];
      logic [29:0] eres[$];
      logic [15:0] a;
      busy_polls = s.busy;
      stall_at   = s.stall;
      rand_bp    = s.bp;
      @(posedge clk); #1;
      wb = nw; rb = nr; qb = nres; db = ndone; ob = overlap; ub = unstable;
      res_base = nres;
      max0 = s.max; run0 = s.run; cmd_valid0 = 1'b1;
      @(posedge clk); #1;
      cmd_valid0 = 1'b0;
      for (int c = 0; c < 3000 && ndone == db; c++) @(negedge clk);
      repeat (4) @(negedge clk);
      rand_bp = 0; stall_at = -1;
      polls = (s.busy >= 4) ? 4 : s.busy + 1;
      for (int p = 0; p < polls; p++) er.push_back(16'hFFF0);
      if (s.busy < 4)
         for (int b = 0; b < 4; b++)
            for (int i = 0; i <= 8; i++) begin
               a = {7'(7'h40 + b), (i == 8) ? 9'h100 : 9'(i)};
               er.push_back(a);
               eres.push_back({4'(b), a[8:0], i == 8, a ^ 16'hA5C3});
            end
      chk("done_cnt", ndone - db, 1);
      chk("n_wr", nw - wb, 3);
      chk("wr_max", wlog[wb % L], {16'hFFF1, s.max});
      chk("wr_run", wlog[(wb + 1) % L], {16'hFFF2, s.run});
      chk("wr_start", wlog[(wb + 2) % L], {16'hFFF0, 16'hFFFF});
      chk("n_rd", nr - rb, er.size());
      n = (nr - rb < er.size()) ? nr - rb : er.size();
      for (int j = 0; j < n; j++) chk("rd_adr", rlog[(rb + j) % L], er[j]);
      chk("n_res", nres - qb, s.exp_nres);
      chk("n_res_model", nres - qb, eres.size());
      n = (nres - qb < eres.size()) ? nres - qb : eres.size();
      for (int j = 0; j < n; j++) chk("res_word", reslog[(qb + j) % L], eres[j]);
      chk("err", err0, s.exp_err);
      chk("wen_ren_overlap", overlap - ob, 0);
      chk("res_stable", unstable - ub, 0);
   endtask
   scn_t tbl [5];
   initial begin
      tbl[0] = '{16'd3, 16'd3, 1, -1, 0, 1'b0, 36};
      tbl[1] = '{16'($urandom), 16'($urandom), 100, -1, 0, 1'b1, 0};
      tbl[2] = '{16'($urandom), 16'($urandom), 0, 3, 0, 1'b0, 36};
      tbl[3] = '{16'($urandom), 16'($urandom), 2, -1, 1, 1'b0, 36};
      tbl[4] = '{16'($urandom), 16'($urandom), 3, -1, 1, 1'b0, 36};
      rst = 1'b1; cmd_valid0 = 1'b0; cmd_valid1 = 1'b0; max0 = '0; run0 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready0, 1);
      chk("rst_wen", wen0, 0);
      chk("rst_ren", ren0, 0);
      chk("rst_adr", {wadr0, radr0}, 0);
      chk("rst_wdata", wdata0, 0);
      chk("rst_res", {res_valid0, res_data0, res_buf0, res_idx0, res_stat0}, 0);
      chk("rst_done_err", {done0, err0}, 0);
      @(posedge clk); #1 rst = 1'b0;
      for (int t = 0; t < 5; t++) run_scn(tbl[t]);
      repeat (5) @(negedge clk);
      chk("err_sticky_idle", err0, 0);
      run_scn(tbl[1]);
      repeat (6) @(negedge clk);
      chk("err_sticky_hold", err0, 1);
      busy_polls = 0;
      @(posedge clk); #1;
      max0 = 16'h1234; run0 = 16'h0042; cmd_valid0 = 1'b1;
      @(posedge clk); #1 cmd_valid0 = 1'b0;
      begin
         int c;
         for (c = 0; c < 3000 && !(res_valid0 && res_buf0 == 4'd2 && res_idx0 == 9'd5); c++) @(negedge clk);
         chk("reach_buf2_idx5", c < 3000, 1);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_res_valid", res_valid0, 0);
      chk("midrst_ren", ren0, 0);
      chk("midrst_cmd_ready", cmd_ready0, 1);
      chk("midrst_outs", {wen0, done0, err0, res_data0, radr0}, 0);
      @(posedge clk); #1 rst = 1'b0;
      run_scn(tbl[0]);
      cmd_valid1 = 1'b1;
      begin
         int c;
         for (c = 0; c < 500 && !done1; c++) @(negedge clk);
         chk("d1_done_seen", c < 500, 1);
      end
      cmd_valid1 = 1'b0;
      repeat (20) @(negedge clk);
      chk("d1_n_wr", nw1, 3);
      chk("d1_n_res", nres1, 1);
      chk("d1_n_done", ndone1, 1);
      chk("d1_rd_adr", last_rd1, 16'h8000);
      chk("d1_res", last_res1, {4'd0, 9'd0, 1'b0, 16'h8000 ^ 16'hA5C3});
      chk("d1_err", err1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
